alu_share_arb: RTL
==================

# alu_share_arb

Two-requester arbiter that shares the single-cycle 32-bit ALU between requesters, e.g. the integer pipeline and the address/branch-compare unit. It grants one request per cycle and drives the ALU operands and control combinationally from the granted request. It captures the ALU result and zero flag into a one-entry response register, which is held on a shared, tagged response channel with valid/ready backpressure.

## Interface
Parameters:
- XLEN, 32, operand/result width; must match the ALU width.
- OPW, 4, ALU control width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m0_valid / m1_valid  in  1  request valid, requester 0 / 1.
- m0_ready / m1_ready  out  1  request accepted this cycle when valid and ready are both high.
- m0_rs1, m0_rs2 / m1_rs1, m1_rs2  in  XLEN  operands.
- m0_op / m1_op  in  OPW  ALU control code.
- alu_rs1, alu_rs2  out  XLEN  to ALU operands.
- alu_ctrl  out  OPW  to ALU control.
- alu_result  in  XLEN  from ALU result.
- alu_zero  in  1  from ALU zero flag.
- resp_valid  out  1  response held.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  1  requester that owns the response.
- resp_result  out  XLEN  captured ALU result.
- resp_zero  out  1  captured zero flag.
- resp_err  out  1  op code was outside the legal set 0000–1001.

## Operation
- FSM with two states:
  - IDLE: response register empty.
  - HOLD: response register full, resp_valid=1.
- can_accept = (state==IDLE) | (state==HOLD & resp_ready).
- grant: combinational pick among valid requesters; only one requester may be granted.
  - mX_ready = can_accept & (grant==X). A ready is never asserted for a non-granted requester.
- alu_rs1/alu_rs2/alu_ctrl = operands/op of the granted requester.
  - When nothing is granted, drive zeros. Op 0000 (ADD of zeros) is the harmless default.
- Accept, i.e. any mX_valid & mX_ready:
  - Capture alu_result and alu_zero into resp_result and resp_zero.
  - resp_id = X.
  - resp_err = (op > 4'b1001). On an illegal op the ALU result (0) and zero flag (1) are still passed through unchanged.
  - Next state HOLD.
- HOLD & resp_ready & no accept → IDLE.
- HOLD & resp_ready & accept → stay HOLD with the new data; back-to-back responses.
- HOLD & !resp_ready: response fields frozen; both readys low.
- Requesters must hold valid and payload stable until accepted. The arbiter does not latch unaccepted requests.
- Round-robin pointer last_id updates only on accept (last_id ← X).

## Timing
- Reset values:
  - state=IDLE, resp_valid=0, resp_id=0, resp_result=0, resp_zero=0, resp_err=0.
  - last_id=1, so requester 0 wins first.
  - m0_ready=m1_ready=0 only while both valids are low.
- Latency: request accepted at edge N → resp_valid=1 from N (visible in cycle N+1).
- Throughput: one response per cycle with resp_ready held high.
- Simultaneous valids: one is granted per arbitration mode (see Configuration); the loser's ready stays 0.
- Asserting rst_n low mid-HOLD discards the held response immediately (asynchronously); no response is delivered after reset.
- The ALU path is combinational from m*_ and selected by grant; the only registers are state, last_id and the response fields.

## Configuration
- ALU_ARB_RR_EN defined: round-robin.
  - When both valids are high, the grant goes to the requester != last_id.
  - With a single valid, that requester is granted.
- ALU_ARB_RR_EN undefined: fixed priority; requester 0 always wins when both are valid.
  - last_id is still kept for debug but does not affect the grant.

## Test plan
- Single request, requester 0:
  - Stimulus: m0 ADD, rs1=5, rs2=7, resp_ready=1.
  - Response: m0_ready=1 in the request cycle; next cycle resp_valid=1, id=0, result=12, zero=0, err=0; then IDLE.
- Backpressure:
  - Stimulus: m1 SUB, 9−9; resp_ready=0 for 3 cycles.
  - Response: result=0, zero=1 held stable; m0_ready=m1_ready=0 while held. When resp_ready rises, IDLE next cycle.
- Contention, both valid for 4 requests each, resp_ready=1:
  - With ALU_ARB_RR_EN: resp_id sequence 0,1,0,1,…
  - Without ALU_ARB_RR_EN: all four requester 0 responses, then requester 1.
- Back-to-back:
  - Stimulus: m0 streams SLL 1<<4, SRA 0x80000000>>>4, SLTU 1<2 with resp_ready=1.
  - Response: responses on consecutive cycles: 16, 0xF8000000, 1.
- Illegal op:
  - Stimulus: op=4'b1100.
  - Response: resp_err=1, result=0, zero=1.
- Reset in HOLD:
  - Stimulus: drop rst_n while resp_valid=1.
  - Response: resp_valid=0 immediately. After release, the first contention grants requester 0.

Source files
------------

// File: rtl/alu_share_arb_if.sv
// Request, ALU and response bundle for the shared-ALU arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// the requesters, the ALU and the response consumer.
interface alu_share_arb_if #(
    parameter int XLEN = 32,
    parameter int OPW  = 4
);
    logic            m0_valid;
    logic            m0_ready;
    logic [XLEN-1:0] m0_rs1;
    logic [XLEN-1:0] m0_rs2;
    logic [OPW-1:0]  m0_op;

    logic            m1_valid;
    logic            m1_ready;
    logic [XLEN-1:0] m1_rs1;
    logic [XLEN-1:0] m1_rs2;
    logic [OPW-1:0]  m1_op;

    logic [XLEN-1:0] alu_rs1;
    logic [XLEN-1:0] alu_rs2;
    logic [OPW-1:0]  alu_ctrl;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    logic            resp_valid;
    logic            resp_ready;
    logic            resp_id;
    logic [XLEN-1:0] resp_result;
    logic            resp_zero;
    logic            resp_err;

    modport slave (
        input  m0_valid, m0_rs1, m0_rs2, m0_op,
        input  m1_valid, m1_rs1, m1_rs2, m1_op,
        input  alu_result, alu_zero, resp_ready,
        output m0_ready, m1_ready,
        output alu_rs1, alu_rs2, alu_ctrl,
        output resp_valid, resp_id, resp_result, resp_zero, resp_err
    );

    modport master (
        output m0_valid, m0_rs1, m0_rs2, m0_op,
        output m1_valid, m1_rs1, m1_rs2, m1_op,
        output alu_result, alu_zero, resp_ready,
        input  m0_ready, m1_ready,
        input  alu_rs1, alu_rs2, alu_ctrl,
        input  resp_valid, resp_id, resp_result, resp_zero, resp_err
    );
endinterface

// File: rtl/alu_share_arb.sv
// Two-requester arbiter in front of a shared single-cycle ALU.
// The ALU operands and control are driven combinationally from the granted
// request. The result is held in a one-entry tagged response register.
// Define ALU_ARB_RR_EN for round-robin grant. When it is not defined, the
// grant uses fixed priority and requester 0 wins.
//
// state | meaning
// IDLE  | response register empty
// HOLD  | response register full, resp_valid=1
module alu_share_arb #(
    parameter int XLEN = 32,
    parameter int OPW  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_share_arb_if.slave     bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state_q, state_d;
    logic            last_id_q, last_id_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_id_q, resp_id_d;
    logic [XLEN-1:0] resp_result_q, resp_result_d;
    logic            resp_zero_q, resp_zero_d;
    logic            resp_err_q, resp_err_d;

    logic            gnt_valid;
    logic            gnt_id;
    logic            can_accept;
    logic            accept;
    logic [OPW-1:0]  sel_op;

    // Grant selection. At most one requester is granted per cycle.
    always_comb begin
        gnt_valid = bus.m0_valid | bus.m1_valid;
`ifdef ALU_ARB_RR_EN
        if (bus.m0_valid && bus.m1_valid)
            gnt_id = ~last_id_q;
        else
            gnt_id = bus.m1_valid;
`else
        gnt_id = ~bus.m0_valid & bus.m1_valid;
`endif
    end

    assign can_accept = (state_q == IDLE) | bus.resp_ready;
    assign accept     = can_accept & gnt_valid;

    assign bus.m0_ready = can_accept & gnt_valid & ~gnt_id;
    assign bus.m1_ready = can_accept & gnt_valid &  gnt_id;

    // Steer the granted operands to the ALU. When nothing is granted, drive
    // zeros, which is op 0000, an ADD of zeros.
    always_comb begin
        bus.alu_rs1  = '0;
        bus.alu_rs2  = '0;
        bus.alu_ctrl = '0;
        if (gnt_valid) begin
            bus.alu_rs1  = gnt_id ? bus.m1_rs1 : bus.m0_rs1;
            bus.alu_rs2  = gnt_id ? bus.m1_rs2 : bus.m0_rs2;
            bus.alu_ctrl = gnt_id ? bus.m1_op  : bus.m0_op;
        end
    end

    assign sel_op = bus.alu_ctrl;

    // Next-state and response capture. The ALU output is taken as-is, even
    // for an illegal op, and is only flagged through resp_err.
    always_comb begin
        state_d       = state_q;
        last_id_d     = last_id_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_zero_d   = resp_zero_q;
        resp_err_d    = resp_err_q;
        if (accept) begin
            state_d       = HOLD;
            last_id_d     = gnt_id;
            resp_id_d     = gnt_id;
            resp_result_d = bus.alu_result;
            resp_zero_d   = bus.alu_zero;
            resp_err_d    = (sel_op > OPW'(9));
        end else if (state_q == HOLD && bus.resp_ready) begin
            state_d = IDLE;
        end
        resp_valid_d = (state_d == HOLD);
    end

    // FSM and response register. Reset discards any held response at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_id_q     <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_result_q <= '0;
            resp_zero_q   <= 1'b0;
            resp_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_id_q     <= last_id_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_zero_q   <= resp_zero_d;
            resp_err_q    <= resp_err_d;
        end
    end

    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_zero   = resp_zero_q;
    assign bus.resp_err    = resp_err_q;
endmodule
